// File: rtl/dot_accum.sv
// dot_accum: two-stage signed multiply-accumulate that sums VEC_LEN operand
// pairs per result and holds each result until downstream accepts it.
//
// Ports:
//   clk       - single clock, all state updates on the rising edge
//   rst       - synchronous active-high reset
//   in_valid  - operand pair present on in_a/in_b
//   in_ready  - pair is accepted this cycle when in_valid is also high
//   in_a      - signed operand A (DATA_WIDTH)
//   in_b      - signed operand B (DATA_WIDTH)
//   out_valid - out_sum holds a finished dot product
//   out_ready - downstream accepts out_sum this cycle
//   out_sum   - signed dot product of one vector, modulo 2^ACC_WIDTH
module dot_accum #(
    parameter int DATA_WIDTH = 19,
    parameter int ACC_WIDTH  = 42,
    parameter int VEC_LEN    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_a,
    input  logic signed [DATA_WIDTH-1:0] in_b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [ACC_WIDTH-1:0]  out_sum
);

    localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);

    logic [CW-1:0]               cnt;
    logic                        p_valid;
    logic                        p_first;
    logic                        p_last;
    logic signed [ACC_WIDTH-1:0] p_prod;
    logic signed [ACC_WIDTH-1:0] acc;

    logic                        stall;
    logic                        accept;
    logic                        advance;
    logic signed [PW-1:0]        prod;
    logic signed [ACC_WIDTH-1:0] sum;

    // Only a finished vector blocked by an unaccepted previous result stalls.
    assign stall    = p_valid && p_last && out_valid && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;
    assign advance  = p_valid && !stall;

    assign prod = PW'(in_a) * PW'(in_b);
    assign sum  = p_first ? p_prod : acc + p_prod;

    // Element counter: tags first/last pair of each vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Stage 1: registered product and its position tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid <= 1'b0;
            p_first <= 1'b0;
            p_last  <= 1'b0;
            p_prod  <= '0;
        end else if (!stall) begin
            p_valid <= accept;
            if (accept) begin
                p_first <= (cnt == '0);
                p_last  <= (cnt == LAST);
                p_prod  <= ACC_WIDTH'(prod);
            end
        end
    end

    // Stage 2: accumulator and held result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
        end else begin
            if (advance) begin
                acc <= sum;
            end
            // A new result may load in the same cycle the old one is taken.
            if (advance && p_last) begin
                out_sum   <= sum;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dot_accum.sv
// tb_dot_accum: directed and randomized checks of dot_accum with
// default parameters (19-bit operands, 42-bit sum, 16-element vectors).
module tb_dot_accum;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [18:0] in_a;
    logic signed [18:0] in_b;
    logic               out_valid;
    logic               out_ready;
    logic signed [41:0] out_sum;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   = 0;
    longint got_q[$];
    longint exp_q[$];

    always #5 clk = ~clk;

    dot_accum dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint wrap42(input longint x);
        logic signed [41:0] t;
        t = x[41:0];
        return longint'(t);
    endfunction

    // Inputs only change at posedge+1, so the state seen at negedge is
    // exactly what the next rising edge will act on.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) got_q.push_back(longint'(out_sum));
        if (!rst && in_valid && in_ready) n_acc++;
    end

    task automatic put(input logic signed [18:0] a, input logic signed [18:0] b);
        int w;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            w++;
            @(negedge clk);
        end
        if (w >= 200) chk("put_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic put_vec(input logic signed [18:0] a, input logic signed [18:0] b);
        for (int i = 0; i < 16; i++) put(a, b);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic compare_results(input string tag);
        chk({tag, "_count"}, longint'(got_q.size()), longint'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk(tag, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        bit done;
        int w;
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_sum", longint'(out_sum), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
        @(posedge clk);
        #1;

        // Basic vector and T+2 latency, one-cycle valid
        put_vec(19'sd1, 19'sd1);
        @(negedge clk);
        chk("lat_t1_valid", longint'(out_valid), 0);
        @(negedge clk);
        chk("lat_t2_valid", longint'(out_valid), 1);
        chk("lat_t2_sum", longint'(out_sum), 16);
        @(negedge clk);
        chk("lat_t3_valid", longint'(out_valid), 0);
        idle(3);
        exp_q.push_back(16);
        compare_results("ones");

        // Extreme operands
        put_vec(-19'sd262144, -19'sd262144);
        put_vec(-19'sd262144, 19'sd262143);
        idle(6);
        exp_q.push_back(64'sd1099511627776);
        exp_q.push_back(-64'sd16 * 64'sd68719214592);
        compare_results("extreme");

        // Back-pressure: hold result, stall second vector's last product
        out_ready = 1'b0;
        n_acc = 0;
        fork
            begin
                put_vec(19'sd2, 19'sd3);
                put_vec(-19'sd1, 19'sd5);
            end
            begin
                w = 0;
                @(negedge clk);
                while (!out_valid && w < 100) begin
                    w++;
                    @(negedge clk);
                end
                chk("bp_first_valid", longint'(out_valid), 1);
                w = 0;
                while (in_ready && w < 100) begin
                    chk("bp_hold_sum", longint'(out_sum), 96);
                    w++;
                    @(negedge clk);
                end
                chk("bp_stall_seen", longint'(in_ready), 0);
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_stall_ready", longint'(in_ready), 0);
                    chk("bp_stall_valid", longint'(out_valid), 1);
                    chk("bp_stall_sum", longint'(out_sum), 96);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(negedge clk);
                @(negedge clk);
                chk("bp_swap_valid", longint'(out_valid), 1);
                chk("bp_swap_sum", longint'(out_sum), -80);
            end
        join
        idle(6);
        chk("bp_pairs", longint'(n_acc), 32);
        exp_q.push_back(96);
        exp_q.push_back(-80);
        compare_results("backpressure");

        // Reset mid-vector discards partial sum
        for (int i = 0; i < 7; i++) put(19'sd1, 19'sd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", longint'(out_valid), 0);
        chk("midrst_ready", longint'(in_ready), 1);
        @(posedge clk);
        #1;
        put_vec(19'sd1, 19'sd1);
        idle(6);
        exp_q.push_back(16);
        compare_results("midreset");

        // Random gaps, random back-pressure, random operands
        done = 1'b0;
        fork
            begin
                for (int v = 0; v < 100; v++) begin
                    longint s;
                    logic signed [18:0] a;
                    logic signed [18:0] b;
                    s = 0;
                    for (int i = 0; i < 16; i++) begin
                        while ($urandom_range(1, 0) == 1) idle(1);
                        a = 19'($urandom);
                        b = 19'($urandom);
                        s += longint'(a) * longint'(b);
                        put(a, b);
                    end
                    exp_q.push_back(wrap42(s));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom);
                end
            end
        join
        out_ready = 1'b1;
        idle(10);
        compare_results("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
